// File: rtl/toggle_event_decoder_if.sv
// Event handshake bundle between the toggle decoder (master) and its consumer (slave).
`timescale 1ns/1ps
interface toggle_event_decoder_if;
  logic evt_valid;
  logic evt_ready;
  logic evt_type;

  modport master (output evt_valid, output evt_type, input evt_ready);
  modport slave  (input evt_valid, input evt_type, output evt_ready);
endinterface

// File: rtl/toggle_event_decoder.sv
// Decodes a T-flip-flop toggle line into set/reset events, queued in a show-ahead
// FIFO with a saturating event counter and a sticky overflow flag.
`timescale 1ns/1ps
module toggle_event_decoder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tog_in,
  input  logic                      clr,
  toggle_event_decoder_if.master    evt_if,
  output logic                      line_q,
  output logic [CNT_W-1:0]          evt_count,
  output logic                      ovf
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [FIFO_DEPTH-1:0]  mem_q, mem_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;

  logic detect;
  logic full;
  logic empty;
  logic pop;
  logic push_ok;

  assign line_q = sync_q[SYNC_STAGES-1];

  // Next-state logic: synchronizer, edge detect, queue bookkeeping, counters.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], tog_in};
    prev_d   = line_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;

    detect  = line_q ^ prev_q;
    full    = (occ_q == OCC_W'(FIFO_DEPTH));
    empty   = (occ_q == '0);
    pop     = !empty && evt_if.evt_ready;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    push_ok = detect && (!full || pop);

    if (push_ok) begin
      mem_d[wr_ptr_q] = line_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push_ok, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (detect && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (detect && full && !pop) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Show-ahead head decode; reads zero when the queue is empty.
  assign evt_if.evt_valid = (occ_q != '0);
  assign evt_if.evt_type  = (occ_q != '0) ? mem_q[rd_ptr_q] : 1'b0;
  assign evt_count        = cnt_q;
  assign ovf              = ovf_q;

endmodule

// File: doc/toggle_event_decoder.md
TOGGLE_EVENT_DECODER -- requirements
Module: toggle_event_decoder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, shall set the synchronizer depth on tog_in (legal range 2..4).
REQ-002 Parameter FIFO_DEPTH, default 4, shall set the event queue depth (power of two, 2..16).
REQ-003 Parameter CNT_W, default 8, shall set the event counter width.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 tog_in  input  1  toggle-encoded line from a T-flip-flop sender; asynchronous to clk; each level change is one event.
REQ-007 evt_valid  output  1  queue head holds an event.
REQ-008 evt_ready  input  1  consumer accepts the head event.
REQ-009 evt_type  output  1  head event type: 1 = set (line went 0->1), 0 = reset (line went 1->0).
REQ-010 line_q  output  1  synchronized tog_in level (last synchronizer stage).
REQ-011 evt_count  output  CNT_W  saturating count of detected events.
REQ-012 ovf  output  1  sticky: at least one event dropped because the queue was full.
REQ-013 clr  input  1  synchronous clear of evt_count and ovf.

Function
REQ-014 tog_in shall pass through a SYNC_STAGES-deep flip-flop chain; line_q = last stage.
REQ-015 A prev register shall hold line_q from the previous cycle; an event shall be detected in any cycle where line_q != prev.
REQ-016 Event type shall be line_q in the detect cycle (1 = rising = set, 0 = falling = reset).
REQ-017 Latency: a tog_in change first captured by stage 0 at edge N shall produce evt_valid=1 after edge N+SYNC_STAGES (after N+2 at default), provided the queue is not full.
REQ-018 A detected event shall be pushed into the queue at the edge ending the detect cycle; only one event per cycle is possible.
REQ-019 Queue shall be show-ahead: evt_type reflects the head whenever evt_valid=1; evt_type = 0 when empty.
REQ-020 Pop shall occur at an edge where evt_valid=1 and evt_ready=1; evt_ready with evt_valid=0 shall have no effect.
REQ-021 evt_valid and evt_type shall stay stable while evt_valid=1 and evt_ready=0.
REQ-022 Push and pop in the same cycle shall both take effect; when full, a simultaneous pop shall free the slot and the push shall be accepted (no drop).
REQ-023 Push while full without pop shall discard the new event, keep queue contents unchanged and set ovf=1 at that edge.
REQ-024 Read/write pointers shall wrap modulo FIFO_DEPTH; occupancy shall be tracked so that full and empty are distinct at wrap.
REQ-025 evt_count shall increment by 1 on every detected event, including dropped ones, and saturate at 2^CNT_W-1.
REQ-026 clr=1 shall force evt_count=0 and ovf=0 at the next edge, overriding any same-cycle increment or drop; queue contents shall be unaffected.
REQ-027 ovf shall remain 1 until clr or reset.

Reset
REQ-028 rst_n=0 shall asynchronously clear all synchronizer stages, prev, queue pointers/occupancy, evt_count and ovf; hence evt_valid=0, evt_type=0, line_q=0, evt_count=0, ovf=0.
REQ-029 Reset asserted mid-operation shall discard all queued events immediately; no event shall be emitted for the reset-induced line_q/prev change.
REQ-030 After rst_n deasserts with tog_in=1, the first 0->1 propagation through the chain shall be reported as one set event.

Verification
REQ-031 Reset, tog_in 0->1 before edge 1, evt_ready=1 -> evt_valid=1 after edge 3 with evt_type=1, popped after edge 4; evt_count=1.
REQ-032 evt_ready=0, five toggles spaced 4 cycles from tog_in=0 -> queue holds types 1,0,1,0; 5th dropped; ovf=1; evt_count=5; drain shows 1,0,1,0 then evt_valid=0.
REQ-033 Queue full, evt_ready=1 in the same cycle as a new event -> no drop, ovf stays 0, occupancy stays 4.
REQ-034 CNT_W=8, 260 toggles with evt_ready=1 -> evt_count=255 held; clr pulse -> evt_count=0, ovf=0 next cycle.
REQ-035 Three events queued, rst_n pulsed low between edges -> evt_valid=0, evt_count=0, line_q=0 immediately, no spurious event after release with tog_in=0.
REQ-036 Back-to-back toggles of tog_in every cycle with evt_ready=1 -> alternating evt_type, one event per cycle, no drop, evt_count equals toggle count.
